instruction_fetcher: RTL and testbench

- Producer end of the instruction-queue push interface.
- Holds the fetch PC and issues one word-fetch at a time to the icache/memory controller.
- Pushes each returned instruction with its PC into the instruction queue, stalling while the queue reports full.
- On a branch roll_back, redirects the PC and discards any in-flight fetch, including the response to an already-committed request.

---
 rtl/instruction_fetcher.sv | 123 ++++++++++++
 tb/tb_instruction_fetcher.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// rtl/instruction_fetcher.sv - single-outstanding instruction fetcher feeding the instruction queue
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic [31:0] roll_back_pc,
    input  logic        isq_full,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_data,
    output logic        instruction_ready,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out
);

    // IDLE: may issue; WAIT: request outstanding; DRAIN: swallow a response orphaned by roll_back
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] PC_INC = 32'(PC_STEP);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_req_q, fetch_req_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        instr_rdy_q, instr_rdy_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic [31:0] pc_out_q, pc_out_d;

    // State register; rdy_in gating lives in the next-state logic so everything holds together
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= 32'h0000_0000;
            instr_rdy_q  <= 1'b0;
            instr_out_q  <= 32'h0000_0000;
            pc_out_q     <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            instr_rdy_q  <= instr_rdy_d;
            instr_out_q  <= instr_out_d;
            pc_out_q     <= pc_out_d;
        end
    end

    // Next-state: roll_back dominates; otherwise issue / wait / drain by state
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_req_d  = fetch_req_q;
        fetch_addr_d = fetch_addr_q;
        instr_rdy_d  = instr_rdy_q;
        instr_out_d  = instr_out_q;
        pc_out_d     = pc_out_q;

        if (rdy_in) begin
            if (roll_back) begin
                // A committed request still owes one response; DRAIN absorbs it unless it is here now
                pc_d        = roll_back_pc;
                instr_rdy_d = 1'b0;
                fetch_req_d = 1'b0;
                unique case (state_q)
                    S_IDLE:  state_d = S_IDLE;
                    S_WAIT:  state_d = fetch_valid ? S_IDLE : S_DRAIN;
                    S_DRAIN: state_d = fetch_valid ? S_IDLE : S_DRAIN;
                    default: state_d = S_IDLE;
                endcase
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        // Waiting one cycle after a push lets isq_full reflect that push
                        instr_rdy_d = 1'b0;
                        if (!isq_full && !instr_rdy_q) begin
                            fetch_req_d  = 1'b1;
                            fetch_addr_d = pc_q;
                            state_d      = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (fetch_valid) begin
                            instr_rdy_d = 1'b1;
                            instr_out_d = fetch_data;
                            pc_out_d    = fetch_addr_q;
                            pc_d        = fetch_addr_q + PC_INC;
                            fetch_req_d = 1'b0;
                            state_d     = S_IDLE;
                        end
                    end
                    S_DRAIN: begin
                        fetch_req_d = 1'b0;
                        if (fetch_valid) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: begin
                        fetch_req_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign fetch_req         = fetch_req_q;
    assign fetch_addr        = fetch_addr_q;
    assign instruction_ready = instr_rdy_q;
    assign instruction_out   = instr_out_q;
    assign pc_out            = pc_out_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb/tb_instruction_fetcher.sv - directed bench for instruction_fetcher
module tb_instruction_fetcher;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        roll_back;
    logic [31:0] roll_back_pc;
    logic        isq_full;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        instruction_ready;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;

    logic        mem_en;
    logic        t_valid;
    logic [31:0] t_data;
    logic        m_valid;
    logic [31:0] m_data;

    assign fetch_valid = mem_en ? m_valid : t_valid;
    assign fetch_data  = mem_en ? m_data  : t_data;

    instruction_fetcher dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .roll_back         (roll_back),
        .roll_back_pc      (roll_back_pc),
        .isq_full          (isq_full),
        .fetch_req         (fetch_req),
        .fetch_addr        (fetch_addr),
        .fetch_valid       (fetch_valid),
        .fetch_data        (fetch_data),
        .instruction_ready (instruction_ready),
        .instruction_out   (instruction_out),
        .pc_out            (pc_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int npass  = 0;
    int ntotal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory model: commit on first sampled fetch_req, answer addr^A5A50000 after mem_lat edges
    int          mem_lat = 1;
    logic        m_pending = 1'b0;
    logic        m_seen = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'h0;
    logic        m_nv;
    logic [31:0] m_nd;
    initial begin
        m_valid = 1'b0;
        m_data  = 32'h0;
    end
    always @(posedge clk_in) begin
        if (!rst_in) begin
            m_pending = 1'b0;
            m_seen    = 1'b0;
            #1 m_valid = 1'b0;
        end else if (rdy_in) begin
            m_nv = 1'b0;
            m_nd = m_data;
            if (fetch_req && !m_seen && !m_pending) begin
                m_pending = 1'b1;
                m_cnt     = mem_lat - 1;
                m_addr    = fetch_addr;
            end
            m_seen = fetch_req;
            if (m_pending) begin
                if (m_cnt == 0) begin
                    m_nv      = 1'b1;
                    m_nd      = m_addr ^ 32'hA5A5_0000;
                    m_pending = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            #1;
            m_valid = m_nv;
            m_data  = m_nd;
        end
    end

    // Queue model: captures a push at each rdy-high edge with the strobe high and no roll_back
    logic [31:0] log_pc[$];
    logic [31:0] log_data[$];
    int          log_edge[$];
    int          edge_cnt = 0;
    int          last_push_edge = 0;
    logic        have_prev = 1'b0;
    logic        full_at_edge = 1'b0;
    always @(posedge clk_in) begin
        if (!rst_in) begin
            have_prev = 1'b0;
        end else if (rdy_in) begin
            edge_cnt++;
            full_at_edge = isq_full;
            if (instruction_ready && !roll_back) begin
                if (have_prev) check("push_gap_ge3", 32'(edge_cnt - last_push_edge >= 3), 32'd1);
                log_pc.push_back(pc_out);
                log_data.push_back(instruction_out);
                log_edge.push_back(edge_cnt);
                last_push_edge = edge_cnt;
                have_prev      = 1'b1;
            end
        end
    end

    // Request-rise watcher: a new request must never be issued while the queue is full
    logic req_prev = 1'b0;
    int   rise_cnt = 0;
    always @(negedge clk_in) begin
        if (rst_in && fetch_req && !req_prev) begin
            rise_cnt++;
            check("issue_while_full", {31'b0, full_at_edge}, 32'd0);
        end
        req_prev = fetch_req;
    end

    task automatic wait_rise(input string what, input int max);
        int start;
        int k;
        start = rise_cnt;
        k = 0;
        while (rise_cnt == start && k < max) begin
            @(negedge clk_in);
            #1;
            k++;
        end
        if (rise_cnt == start) check({"timeout_rise_", what}, 32'd0, 32'd1);
    endtask

    task automatic wait_pushes(input string what, input int n, input int max);
        int k;
        k = 0;
        while (log_pc.size() < n && k < max) begin
            @(negedge clk_in);
            #1;
            k++;
        end
        if (log_pc.size() < n) check({"timeout_push_", what}, 32'(log_pc.size()), 32'(n));
    endtask

    typedef struct {
        logic        rb;
        logic [31:0] rb_pc;
        logic        full;
        logic        fv;
        logic [31:0] fd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ir;
        logic [31:0] e_out;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[28];

    initial begin
        int          n;
        logic [31:0] held_pc;
        logic [31:0] held_out;
        logic [31:0] last_pc;

        //          rb  rb_pc         full fv  fd             req addr          ir  out            pc
        vecs[0]  = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h0,        0,  32'h0,         32'h0};
        vecs[1]  = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h0,        0,  32'h0,         32'h0};
        vecs[2]  = '{0, 32'h0,        0,   1,  32'hA5A50000,  0,  32'h0,        1,  32'hA5A50000,  32'h0};
        vecs[3]  = '{0, 32'h0,        0,   0,  32'h0,         0,  32'h0,        0,  32'hA5A50000,  32'h0};
        vecs[4]  = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h4,        0,  32'hA5A50000,  32'h0};
        vecs[5]  = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h4,        0,  32'hA5A50000,  32'h0};
        vecs[6]  = '{0, 32'h0,        0,   1,  32'hA5A50004,  0,  32'h4,        1,  32'hA5A50004,  32'h4};
        vecs[7]  = '{0, 32'h0,        1,   0,  32'h0,         0,  32'h4,        0,  32'hA5A50004,  32'h4};
        vecs[8]  = '{0, 32'h0,        1,   0,  32'h0,         0,  32'h4,        0,  32'hA5A50004,  32'h4};
        vecs[9]  = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h8,        0,  32'hA5A50004,  32'h4};
        vecs[10] = '{1, 32'h1000,     0,   0,  32'h0,         0,  32'h8,        0,  32'hA5A50004,  32'h4};
        vecs[11] = '{0, 32'h0,        0,   0,  32'h0,         0,  32'h8,        0,  32'hA5A50004,  32'h4};
        vecs[12] = '{0, 32'h0,        0,   1,  32'hDEADBEEF,  0,  32'h8,        0,  32'hA5A50004,  32'h4};
        vecs[13] = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h1000,     0,  32'hA5A50004,  32'h4};
        vecs[14] = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h1000,     0,  32'hA5A50004,  32'h4};
        vecs[15] = '{1, 32'h2000,     0,   1,  32'h0BADF00D,  0,  32'h1000,     0,  32'hA5A50004,  32'h4};
        vecs[16] = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h2000,     0,  32'hA5A50004,  32'h4};
        vecs[17] = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h2000,     0,  32'hA5A50004,  32'h4};
        vecs[18] = '{0, 32'h0,        0,   1,  32'h12345678,  0,  32'h2000,     1,  32'h12345678,  32'h2000};
        vecs[19] = '{1, 32'h3000,     0,   0,  32'h0,         0,  32'h2000,     0,  32'h12345678,  32'h2000};
        vecs[20] = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h3000,     0,  32'h12345678,  32'h2000};
        vecs[21] = '{1, 32'h4000,     0,   0,  32'h0,         0,  32'h3000,     0,  32'h12345678,  32'h2000};
        vecs[22] = '{1, 32'h4800,     0,   0,  32'h0,         0,  32'h3000,     0,  32'h12345678,  32'h2000};
        vecs[23] = '{1, 32'h5000,     0,   1,  32'hFFFFFFFF,  0,  32'h3000,     0,  32'h12345678,  32'h2000};
        vecs[24] = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h5000,     0,  32'h12345678,  32'h2000};
        vecs[25] = '{0, 32'h0,        0,   0,  32'h0,         1,  32'h5000,     0,  32'h12345678,  32'h2000};
        vecs[26] = '{0, 32'h0,        0,   1,  32'hCAFE0000,  0,  32'h5000,     1,  32'hCAFE0000,  32'h5000};
        vecs[27] = '{0, 32'h0,        0,   0,  32'h0,         0,  32'h5000,     0,  32'hCAFE0000,  32'h5000};

        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        roll_back    = 1'b0;
        roll_back_pc = 32'h0;
        isq_full     = 1'b0;
        mem_en       = 1'b0;
        t_valid      = 1'b0;
        t_data       = 32'h0;

        repeat (2) @(negedge clk_in);
        check("rst_fetch_req", {31'b0, fetch_req}, 32'd0);
        check("rst_fetch_addr", fetch_addr, 32'h0);
        check("rst_instr_ready", {31'b0, instruction_ready}, 32'd0);
        check("rst_instr_out", instruction_out, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        rst_in = 1'b1;

        // Cycle-by-cycle table with the bench acting as memory
        for (int i = 0; i < 28; i++) begin
            roll_back    = vecs[i].rb;
            roll_back_pc = vecs[i].rb_pc;
            isq_full     = vecs[i].full;
            t_valid      = vecs[i].fv;
            t_data       = vecs[i].fd;
            @(negedge clk_in);
            ntotal++;
            if (fetch_req === vecs[i].e_req && fetch_addr === vecs[i].e_addr &&
                instruction_ready === vecs[i].e_ir && instruction_out === vecs[i].e_out &&
                pc_out === vecs[i].e_pc) begin
                npass++;
            end else begin
                $display("FAIL vec%0d: got req=%b addr=%h ir=%b out=%h pc=%h expected req=%b addr=%h ir=%b out=%h pc=%h",
                         i, fetch_req, fetch_addr, instruction_ready, instruction_out, pc_out,
                         vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ir, vecs[i].e_out, vecs[i].e_pc);
            end
        end
        roll_back = 1'b0;
        t_valid   = 1'b0;

        // Asynchronous reset in the middle of a WAIT
        mem_en = 1'b1;
        wait_rise("pre_reset", 10);
        rst_in = 1'b0;
        #1;
        check("midwait_rst_req", {31'b0, fetch_req}, 32'd0);
        check("midwait_rst_addr", fetch_addr, 32'h0);
        check("midwait_rst_pc_out", pc_out, 32'h0);
        repeat (2) @(negedge clk_in);
        log_pc.delete();
        log_data.delete();
        log_edge.delete();
        rst_in = 1'b1;

        // Streaming from reset with 1-cycle memory
        wait_pushes("stream", 4, 60);
        for (int i = 0; i < 4 && i < log_pc.size(); i++) begin
            check($sformatf("stream_pc%0d", i), log_pc[i], 32'(4 * i));
            check($sformatf("stream_data%0d", i), log_data[i], 32'(4 * i) ^ 32'hA5A5_0000);
        end
        if (log_edge.size() >= 3) check("stream_period", 32'(log_edge[2] - log_edge[1]), 32'd4);

        // Queue full: no new issue, resume at last pc_out+4
        isq_full = 1'b1;
        repeat (20) @(negedge clk_in);
        check("full_req_low", {31'b0, fetch_req}, 32'd0);
        n = log_pc.size();
        last_pc = (n > 0) ? log_pc[n - 1] : 32'h0;
        isq_full = 1'b0;
        wait_rise("full_release", 20);
        check("full_resume_addr", fetch_addr, last_pc + 32'd4);
        wait_pushes("after_full", n + 2, 40);
        for (int i = 0; i < log_pc.size(); i++) begin
            check($sformatf("seq_pc%0d", i), log_pc[i], 32'(4 * i));
        end

        // rdy_in low while a push strobe is pending
        begin
            int k;
            k = 0;
            while (!instruction_ready && k < 20) begin
                @(negedge clk_in);
                k++;
            end
            if (!instruction_ready) check("timeout_ir_high", 32'd0, 32'd1);
        end
        n        = log_pc.size();
        held_pc  = pc_out;
        held_out = instruction_out;
        rdy_in   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check($sformatf("frozen_ir%0d", i), {31'b0, instruction_ready}, 32'd1);
        end
        check("frozen_pc_out", pc_out, held_pc);
        check("frozen_instr_out", instruction_out, held_out);
        check("frozen_no_capture", 32'(log_pc.size()), 32'(n));
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("unfreeze_ir_clear", {31'b0, instruction_ready}, 32'd0);
        check("unfreeze_one_push", 32'(log_pc.size()), 32'(n + 1));
        if (log_pc.size() > 0) check("unfreeze_push_pc", log_pc[log_pc.size() - 1], held_pc);

        // PC wrap through a roll_back to the last word
        isq_full = 1'b1;
        repeat (20) @(negedge clk_in);
        roll_back    = 1'b1;
        roll_back_pc = 32'hFFFF_FFFC;
        isq_full     = 1'b0;
        @(negedge clk_in);
        roll_back = 1'b0;
        n = log_pc.size();
        wait_pushes("wrap", n + 1, 30);
        if (log_pc.size() > n) begin
            check("wrap_pc", log_pc[n], 32'hFFFF_FFFC);
            check("wrap_data", log_data[n], 32'h5A5A_FFFC);
        end
        wait_rise("wrap_next", 20);
        check("wrap_next_addr", fetch_addr, 32'h0000_0000);

        // roll_back during WAIT with a slow memory: late response is dropped
        mem_lat = 4;
        wait_rise("slow_issue", 20);
        @(negedge clk_in);
        roll_back    = 1'b1;
        roll_back_pc = 32'h0000_1000;
        @(negedge clk_in);
        roll_back = 1'b0;
        n = log_pc.size();
        wait_rise("after_drain", 30);
        check("drain_next_addr", fetch_addr, 32'h0000_1000);
        check("drain_no_push", 32'(log_pc.size()), 32'(n));
        wait_pushes("drain_push", n + 1, 30);
        if (log_pc.size() > n) begin
            check("drain_push_pc", log_pc[n], 32'h0000_1000);
            check("drain_push_data", log_data[n], 32'hA5A5_1000);
        end

        repeat (3) @(negedge clk_in);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
